pixel_mem_arbiter: RTL and testbench
====================================

Name: pixel_mem_arbiter

Overview:
- Shares one single-port 16-bit pixel memory (SPRAM/BRAM) between NUM_REQUESTERS LED-driver output engines and one frame writer (e.g. SPI/host frame loader).
- Each output engine holds a level read request until it receives a one-cycle finished strobe, using the same request/finished handshake the output engines already use.
- Reads are granted round-robin; writes alternate fairly with reads. At most one read is outstanding; memory read latency is fixed.

Parameters:
- NUM_REQUESTERS, 4, number of read clients (1..8).
- ADDRESS_BUS_WIDTH, 12, memory address width; same value as the output engines.
- MEM_LATENCY, 2, number of rising edges from mem_address update until mem_read_data is sampled (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- read_address_bus  in  NUM_REQUESTERS*ADDRESS_BUS_WIDTH  requester i address at slice [i*A +: A].
- read_strobe_bus  in  NUM_REQUESTERS  level request; held high by requester i until its finished strobe.
- read_data  out  16  last completed read word; shared by all requesters.
- read_finished_strobe_bus  out  NUM_REQUESTERS  one-cycle pulse to the granted requester; read_data is valid in the same cycle.
- write_request  in  1  level write request from the frame writer.
- write_address  in  ADDRESS_BUS_WIDTH  write address.
- write_data  in  16  write word.
- write_ack  out  1  one-cycle pulse when the write is issued.
- mem_address  out  ADDRESS_BUS_WIDTH  memory address (registered).
- mem_write_data  out  16  memory write data (registered).
- mem_write_enable  out  1  memory write enable (registered, one cycle per write).
- mem_read_data  in  16  memory read data.
- busy  out  1  high while in READ_WAIT.

Behaviour:
- Reset (async, rst=1): all outputs are 0, state=IDLE, rr_last=NUM_REQUESTERS-1 (requester 0 has first priority), mask=0, write_turn=0, latency counter=0.
- A reset asserted mid-read abandons that read: no finished strobe is issued, and the requester keeps its request pending.
- Defaults every cycle: read_finished_strobe_bus=0, write_ack=0, mem_write_enable=0.
- Eligible read set: read_strobe_bus & ~mask.
- mask bit i is set only on the cycle immediately after requester i's finished strobe. This absorbs the one-cycle request tail left by a registered set/reset flop. mask clears on the following edge.
- IDLE state, decision taken each edge:
  - If write_request=1 and (no eligible read or write_turn=1):
    - mem_address<=write_address, mem_write_data<=write_data, mem_write_enable<=1, write_ack<=1.
    - write_turn<=0; stay in IDLE.
    - The writer must drop or change its request after write_ack; a still-high write_request is treated as a new write.
  - Else if any eligible read:
    - g = first eligible index after rr_last, searching upward with wrap-around.
    - mem_address<=read_address_bus[g]; rr_last<=g; counter<=MEM_LATENCY; write_turn<=write_request; go to READ_WAIT.
  - Else stay in IDLE; outputs hold their values.
- READ_WAIT state:
  - counter decrements each edge; no writes are accepted; mem_address holds its value.
  - On the edge where counter==1: read_data<=mem_read_data, read_finished_strobe_bus[g]<=1, mask[g]<=1, go to IDLE.
- Timing:
  - Read latency is MEM_LATENCY+1 edges from request seen in IDLE to finished strobe (3 cycles at default).
  - Peak throughput is one read per MEM_LATENCY+1 cycles.
  - A write costs 1 cycle.
- Fairness:
  - A pending write waits at most one read.
  - A pending read waits at most (NUM_REQUESTERS-1) reads plus one write per read.
- Requester address changes while waiting are taken as-is; the address is sampled only on the grant edge.
- A request dropped before grant is simply not served.
- read_data holds its value between completions.
- Simultaneous write_request and reads after a read completes: the write goes first (write_turn=1).

Test Plan:
- Reset then a single read: mem_read_data model returns addr+0x100 with latency 2. Requester 1 requests addr 0x005. Expected: mem_address=0x005 one edge later; read_finished_strobe_bus=4'b0010 exactly 3 edges after the request; read_data=0x0105.
- All 4 requesters request continuously with srff-style clearing: grant order is 0,1,2,3,0. No requester receives two strobes without the other three being served in between. No double grant from the request tail (mask check).
- Write only: write_request with 0x010/0xBEEF. Expected: mem_write_enable=1, mem_address=0x010, mem_write_data=0xBEEF for exactly one cycle, with write_ack in the same cycle. A subsequent read of 0x010 from a RAM model returns 0xBEEF.
- Write and reads contending: write_request held (re-issued after each ack) while requester 0 reads continuously. Writes and reads alternate 1:1. Neither client is starved over 20 transactions.
- Reset mid-operation: assert rst during READ_WAIT. All outputs are 0 immediately (asynchronous); no finished strobe occurs. After release, the still-pending request completes normally with correct data.
- MEM_LATENCY=1 build: a read completes in 2 edges. Back-to-back reads from two requesters occur every 2 cycles.

Source files
------------

// File: rtl/pixel_mem_arbiter.sv
// rtl/pixel_mem_arbiter.sv - shares one single-port pixel memory between
// round-robin LED output engine reads and a frame writer.
module pixel_mem_arbiter #(
  parameter int NUM_REQUESTERS    = 4,
  parameter int ADDRESS_BUS_WIDTH = 12,
  parameter int MEM_LATENCY       = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [NUM_REQUESTERS*ADDRESS_BUS_WIDTH-1:0] read_address_bus,
  input  logic [NUM_REQUESTERS-1:0]                   read_strobe_bus,
  output logic [15:0]                                 read_data,
  output logic [NUM_REQUESTERS-1:0]                   read_finished_strobe_bus,
  input  logic                                        write_request,
  input  logic [ADDRESS_BUS_WIDTH-1:0]                write_address,
  input  logic [15:0]                                 write_data,
  output logic                                        write_ack,
  output logic [ADDRESS_BUS_WIDTH-1:0]                mem_address,
  output logic [15:0]                                 mem_write_data,
  output logic                                        mem_write_enable,
  input  logic [15:0]                                 mem_read_data,
  output logic                                        busy
);

  localparam int IW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam int CW = $clog2(MEM_LATENCY + 1);

  typedef enum logic {IDLE, READ_WAIT} state_t;

  state_t                         state;
  logic [IW-1:0]                  rr_last;
  logic [NUM_REQUESTERS-1:0]      mask;
  logic                           write_turn;
  logic [CW-1:0]                  counter;

  logic [NUM_REQUESTERS-1:0]      eligible;
  logic [NUM_REQUESTERS-1:0]      grant_onehot;
  logic [IW-1:0]                  idx;
  logic [IW-1:0]                  pick;
  logic                           pick_valid;
  logic [ADDRESS_BUS_WIDTH-1:0]   req_addr [NUM_REQUESTERS];

  for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : g_addr
    assign req_addr[g] = read_address_bus[g*ADDRESS_BUS_WIDTH +: ADDRESS_BUS_WIDTH];
  end

  assign grant_onehot = NUM_REQUESTERS'(1) << rr_last;

  // Walk upward from the last grant with wrap-around; first eligible wins.
  always_comb begin
    eligible   = read_strobe_bus & ~mask;
    pick       = rr_last;
    pick_valid = 1'b0;
    idx        = rr_last;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      idx = (idx == IW'(NUM_REQUESTERS - 1)) ? '0 : idx + 1'b1;
      if (!pick_valid && eligible[idx]) begin
        pick       = idx;
        pick_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                    <= IDLE;
      rr_last                  <= IW'(NUM_REQUESTERS - 1);
      mask                     <= '0;
      write_turn               <= 1'b0;
      counter                  <= '0;
      read_data                <= '0;
      read_finished_strobe_bus <= '0;
      write_ack                <= 1'b0;
      mem_address              <= '0;
      mem_write_data           <= '0;
      mem_write_enable         <= 1'b0;
      busy                     <= 1'b0;
    end else begin
      read_finished_strobe_bus <= '0;
      write_ack                <= 1'b0;
      mem_write_enable         <= 1'b0;
      mask                     <= '0;
      case (state)
        IDLE: begin
          if (write_request && (!pick_valid || write_turn)) begin
            mem_address      <= write_address;
            mem_write_data   <= write_data;
            mem_write_enable <= 1'b1;
            write_ack        <= 1'b1;
            write_turn       <= 1'b0;
          end else if (pick_valid) begin
            mem_address <= req_addr[pick];
            rr_last     <= pick;
            counter     <= CW'(MEM_LATENCY);
            write_turn  <= write_request;
            busy        <= 1'b1;
            state       <= READ_WAIT;
          end
        end
        READ_WAIT: begin
          counter <= counter - 1'b1;
          if (counter == CW'(1)) begin
            // Mask hides the granted requester's request tail for one cycle.
            read_data                <= mem_read_data;
            read_finished_strobe_bus <= grant_onehot;
            mask                     <= grant_onehot;
            busy                     <= 1'b0;
            state                    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_mem_arbiter.sv
// tb/tb_pixel_mem_arbiter.sv - directed and random checks of pixel_mem_arbiter
// against a round-robin / RAM reference model.
module tb_pixel_mem_arbiter;
  localparam int N = 4;
  localparam int A = 12;
  localparam int L = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [N*A-1:0] read_address_bus = '0;
  logic [N-1:0]   read_strobe_bus = '0;
  logic [15:0]    read_data;
  logic [N-1:0]   read_finished_strobe_bus;
  logic           write_request = 1'b0;
  logic [A-1:0]   write_address = '0;
  logic [15:0]    write_data = '0;
  logic           write_ack;
  logic [A-1:0]   mem_address;
  logic [15:0]    mem_write_data;
  logic           mem_write_enable;
  logic [15:0]    mem_read_data;
  logic           busy;

  pixel_mem_arbiter #(.NUM_REQUESTERS(N), .ADDRESS_BUS_WIDTH(A), .MEM_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .read_address_bus(read_address_bus), .read_strobe_bus(read_strobe_bus),
    .read_data(read_data), .read_finished_strobe_bus(read_finished_strobe_bus),
    .write_request(write_request), .write_address(write_address), .write_data(write_data),
    .write_ack(write_ack), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data), .busy(busy)
  );

  // Second instance: two requesters, single-cycle combinational memory.
  logic [2*A-1:0] rab1 = '0;
  logic [1:0]     rsb1 = '0;
  logic [15:0]    rd1;
  logic [1:0]     rfs1;
  logic           wreq1 = 1'b0;
  logic [A-1:0]   wa1 = '0;
  logic [15:0]    wd1 = '0;
  logic           wack1, mwe1, busy1;
  logic [A-1:0]   ma1;
  logic [15:0]    mwd1, mrd1;
  assign mrd1 = 16'h0200 + 16'(ma1);

  pixel_mem_arbiter #(.NUM_REQUESTERS(2), .ADDRESS_BUS_WIDTH(A), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .read_address_bus(rab1), .read_strobe_bus(rsb1),
    .read_data(rd1), .read_finished_strobe_bus(rfs1),
    .write_request(wreq1), .write_address(wa1), .write_data(wd1),
    .write_ack(wack1), .mem_address(ma1), .mem_write_data(mwd1),
    .mem_write_enable(mwe1), .mem_read_data(mrd1), .busy(busy1)
  );

  // Synchronous RAM with one output register: latency 2 from address update.
  logic [15:0] ram [1<<A];
  bit          ram_written [1<<A];
  logic [15:0] ram_q;
  always @(posedge clk) begin
    if (mem_write_enable) begin
      ram[mem_address]         <= mem_write_data;
      ram_written[mem_address] <= 1'b1;
    end
    ram_q <= ram_written[mem_address] ? ram[mem_address] : 16'h0100 + 16'(mem_address);
  end
  assign mem_read_data = ram_q;

  int vectors = 0;
  int miscompares = 0;

  logic [N-1:0]   strobe_prev;
  logic [N-1:0]   rehold;
  logic [N-1:0]   elig_hist[$];
  logic [N*A-1:0] addr_hist[$];
  int             last_served;
  bit             mon_on;
  bit             auto_rewrite;
  logic [15:0]    m_ram [1<<A];
  bit             m_written [1<<A];
  int             other_served [N];
  int             served_cnt [N];
  int             reads_while_wpend;
  int             write_cnt;
  int             grant_q[$];
  bit             ev_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] elig, input int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (elig[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [15:0] model_rd(input logic [A-1:0] a);
    return m_written[a] ? m_ram[a] : 16'h0100 + 16'(a);
  endfunction

  task automatic reset_model();
    elig_hist.delete();
    addr_hist.delete();
    last_served = N - 1;
    strobe_prev = '0;
    reads_while_wpend = 0;
    for (int i = 0; i < N; i++) other_served[i] = 0;
  endtask

  task automatic monitor();
    if (read_finished_strobe_bus != '0) begin
      int h, w;
      logic [A-1:0] a;
      h = elig_hist.size() - 1 - L;
      if (h < 0) check("strobe_without_grant", 32'd1, 32'd0);
      else begin
        w = rr_pick(elig_hist[h], last_served);
        check("grant_order", 32'(read_finished_strobe_bus), (w < 0) ? 32'd0 : (32'd1 << w));
        if (w >= 0) begin
          a = addr_hist[h][w*A +: A];
          check("read_data", 32'(read_data), 32'(model_rd(a)));
          check("read_fairness", 32'(other_served[w] <= N - 1), 32'd1);
          for (int j = 0; j < N; j++)
            if (j != w && read_strobe_bus[j]) other_served[j]++;
          other_served[w] = 0;
          served_cnt[w]++;
          last_served = w;
          grant_q.push_back(w);
          ev_q.push_back(1'b0);
          if (write_request) begin
            reads_while_wpend++;
            check("write_fairness", 32'(reads_while_wpend <= 2), 32'd1);
          end
        end
      end
    end
    if (write_ack || mem_write_enable) begin
      check("we_with_ack", 32'(mem_write_enable), 32'(write_ack));
      check("wr_addr", 32'(mem_address), 32'(write_address));
      check("wr_data", 32'(mem_write_data), 32'(write_data));
      m_ram[write_address] = write_data;
      m_written[write_address] = 1'b1;
      write_cnt++;
      reads_while_wpend = 0;
      ev_q.push_back(1'b1);
      if (auto_rewrite) begin
        write_address = A'($urandom_range(0, 63));
        write_data = 16'($urandom);
      end else write_request = 1'b0;
    end
  endtask

  // One clock: snapshot what the coming edge sees, then emulate set/reset-flop requesters.
  task automatic tick();
    if (mon_on) begin
      elig_hist.push_back(read_strobe_bus & ~strobe_prev);
      addr_hist.push_back(read_address_bus);
    end
    @(posedge clk);
    #1;
    if (mon_on) monitor();
    read_strobe_bus = (read_strobe_bus & ~strobe_prev) | (strobe_prev & rehold);
    strobe_prev = read_finished_strobe_bus;
  endtask

  task automatic do_reset();
    mon_on = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    reset_model();
    mon_on = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cnt, lat;
    bit done;
    rehold = '0;
    auto_rewrite = 1'b0;
    mon_on = 1'b0;
    write_cnt = 0;
    for (int i = 0; i < N; i++) served_cnt[i] = 0;
    reset_model();

    // Reset values
    #2 rst = 1'b1;
    #1;
    check("rst_read_data", 32'(read_data), 32'd0);
    check("rst_strobe", 32'(read_finished_strobe_bus), 32'd0);
    check("rst_write_ack", 32'(write_ack), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);
    check("rst_mem_write_data", 32'(mem_write_data), 32'd0);
    check("rst_mem_we", 32'(mem_write_enable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobe1", 32'(rfs1), 32'd0);
    @(negedge clk) rst = 1'b0;
    reset_model();
    mon_on = 1'b1;

    // Single read by requester 1, then the request tail must not regrant
    read_address_bus[1*A +: A] = 12'h005;
    read_strobe_bus[1] = 1'b1;
    tick();
    check("t1_mem_address", 32'(mem_address), 32'h005);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_strobe_e1", 32'(read_finished_strobe_bus), 32'd0);
    tick();
    check("t1_strobe_e2", 32'(read_finished_strobe_bus), 32'd0);
    tick();
    check("t1_strobe_e3", 32'(read_finished_strobe_bus), 32'b0010);
    check("t1_read_data", 32'(read_data), 32'h0105);
    tick();
    check("t1_tail_busy", 32'(busy), 32'd0);
    check("t1_tail_strobe", 32'(read_finished_strobe_bus), 32'd0);
    check("t1_hold_address", 32'(mem_address), 32'h005);
    tick();
    check("t1_idle", 32'(busy), 32'd0);

    // All four requesters continuously: order 0,1,2,3,0,...
    do_reset();
    for (int i = 0; i < N; i++) read_address_bus[i*A +: A] = A'(12'h040 + i);
    rehold = '1;
    read_strobe_bus = '1;
    grant_q.delete();
    cnt = 0;
    while (grant_q.size() < 8 && cnt < 60) begin tick(); cnt++; end
    check("t2_grants_seen", 32'(grant_q.size() >= 8), 32'd1);
    for (int k = 0; k < 8 && k < grant_q.size(); k++)
      check("t2_grant_order", 32'(grant_q[k]), 32'(k % N));
    rehold = '0;
    cnt = 0;
    while ((read_strobe_bus != '0 || busy) && cnt < 40) begin tick(); cnt++; end
    check("t2_drained", 32'(read_strobe_bus == '0 && !busy), 32'd1);

    // Single write, then read it back
    write_address = 12'h010;
    write_data = 16'hBEEF;
    write_request = 1'b1;
    tick();
    check("t3_we", 32'(mem_write_enable), 32'd1);
    check("t3_addr", 32'(mem_address), 32'h010);
    check("t3_data", 32'(mem_write_data), 32'hBEEF);
    check("t3_ack", 32'(write_ack), 32'd1);
    tick();
    check("t3_we_one_cycle", 32'(mem_write_enable), 32'd0);
    check("t3_ack_one_cycle", 32'(write_ack), 32'd0);
    read_address_bus[2*A +: A] = 12'h010;
    read_strobe_bus[2] = 1'b1;
    cnt = 0;
    do begin tick(); cnt++; end while (read_finished_strobe_bus == '0 && cnt < 10);
    check("t3_read_strobe", 32'(read_finished_strobe_bus), 32'b0100);
    check("t3_read_back", 32'(read_data), 32'hBEEF);
    tick();
    tick();

    // Write held against continuous reads by requester 0: strict alternation
    ev_q.delete();
    rehold = 4'b0001;
    read_address_bus[0 +: A] = 12'h020;
    read_strobe_bus[0] = 1'b1;
    write_address = A'($urandom_range(0, 63));
    write_data = 16'($urandom);
    write_request = 1'b1;
    auto_rewrite = 1'b1;
    cnt = 0;
    while (ev_q.size() < 20 && cnt < 120) begin tick(); cnt++; end
    check("t4_events_seen", 32'(ev_q.size() >= 20), 32'd1);
    for (int k = 1; k < 20 && k < ev_q.size(); k++)
      check("t4_alternate", 32'(ev_q[k] != ev_q[k-1]), 32'd1);
    auto_rewrite = 1'b0;
    rehold = '0;
    cnt = 0;
    while ((read_strobe_bus != '0 || write_request || busy) && cnt < 40) begin tick(); cnt++; end
    check("t4_drained", 32'(read_strobe_bus == '0 && !write_request && !busy), 32'd1);

    // Reset during READ_WAIT abandons the read; the pending request is served afterwards
    read_address_bus[3*A +: A] = 12'h033;
    read_strobe_bus[3] = 1'b1;
    tick();
    check("t5_busy", 32'(busy), 32'd1);
    mon_on = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t5_busy_rst", 32'(busy), 32'd0);
    check("t5_addr_rst", 32'(mem_address), 32'd0);
    check("t5_data_rst", 32'(read_data), 32'd0);
    check("t5_wdata_rst", 32'(mem_write_data), 32'd0);
    check("t5_strobe_rst", 32'(read_finished_strobe_bus), 32'd0);
    @(posedge clk);
    #1;
    check("t5_no_strobe", 32'(read_finished_strobe_bus), 32'd0);
    @(negedge clk) rst = 1'b0;
    reset_model();
    mon_on = 1'b1;
    lat = 0;
    do begin tick(); lat++; end while (read_finished_strobe_bus == '0 && lat < 10);
    check("t5_latency", 32'(lat), 32'd3);
    check("t5_strobe", 32'(read_finished_strobe_bus), 32'b1000);
    check("t5_data", 32'(read_data), 32'h0133);
    tick();
    tick();

    // MEM_LATENCY=1 instance: two requesters held, a completion every 2 cycles
    rab1 = {12'h00B, 12'h00A};
    rsb1 = 2'b11;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t % 2 == 1) check("t6_idle_cycle", 32'(rfs1), 32'd0);
      else begin
        check("t6_strobe", 32'(rfs1), ((t / 2) % 2 == 1) ? 32'b01 : 32'b10);
        check("t6_data", 32'(rd1), ((t / 2) % 2 == 1) ? 32'h020A : 32'h020B);
      end
    end
    rsb1 = 2'b00;

    // Random traffic against the reference model
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!read_strobe_bus[i] && $urandom_range(0, 3) == 0) begin
          read_address_bus[i*A +: A] = A'($urandom_range(0, 63));
          read_strobe_bus[i] = 1'b1;
        end else if (read_strobe_bus[i] && $urandom_range(0, 7) == 0)
          read_address_bus[i*A +: A] = A'($urandom_range(0, 63));
      end
      if (!write_request && $urandom_range(0, 5) == 0) begin
        write_address = A'($urandom_range(0, 63));
        write_data = 16'($urandom);
        write_request = 1'b1;
      end
      tick();
    end
    cnt = 0;
    done = 1'b0;
    while (!done && cnt < 200) begin
      tick();
      cnt++;
      done = (read_strobe_bus == '0 && !write_request && !busy);
    end
    check("t7_drained", 32'(done), 32'd1);
    for (int i = 0; i < N; i++) check("t7_served", 32'(served_cnt[i] > 0), 32'd1);
    check("t7_writes", 32'(write_cnt > 2), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
